// File: rtl/nabp_swap_pkg.sv
// Shared types and helpers for the N-bank swap rotator.
// Optional stall statistics are enabled with SWAP_ROTATOR_STATS_EN (see nabp_swap_rotator).
package nabp_swap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PREPROCESS = 2'd1,
    ST_FILL       = 2'd2,
    ST_DRAIN      = 2'd3
  } state_e;

  localparam int unsigned STALL_W = 32;

  // One-hot of a bank index; callers truncate to their bank count.
  function automatic logic [31:0] onehot32(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

  // Modulo increment with an explicit wrap compare (works for non-power-of-2 moduli).
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned modulus);
    return ((v + 32'd1) == modulus) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/nabp_wrap_counter.sv
// Modulo-MODULUS counter with increment enable, used for the fill and shift bank pointers.
module nabp_wrap_counter
  import nabp_swap_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned W       = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) value_d = W'(wrap_inc(32'(value_q), MODULUS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/nabp_swap_rotator.sv
// Rotates NUM_BANKS line buffers through fill -> shift roles for one projection pass.
// Define SWAP_ROTATOR_STATS_EN to add the stall_cycles queue-full counter output.
module nabp_swap_rotator
  import nabp_swap_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned NUM_ANGLES = 180,
  parameter int unsigned BANK_W     = $clog2(NUM_BANKS),
  parameter int unsigned ANGLE_W    = $clog2(NUM_ANGLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 na_kick,
  input  logic                 preprocess_done,
  input  logic [NUM_BANKS-1:0] sw_swap_ready,
  input  logic [NUM_BANKS-1:0] sw_next_itr,
  output logic [NUM_BANKS-1:0] sw_swap,
  output logic [NUM_BANKS-1:0] sw_next_itr_ack,
  output logic [BANK_W-1:0]    fill_sel,
  output logic [BANK_W-1:0]    shift_sel,
  output logic [ANGLE_W-1:0]   angle,
  output logic                 pe_kick,
  output logic                 pe_en,
  output logic                 pe_scan_mode,
  output logic                 pass_done
`ifdef SWAP_ROTATOR_STATS_EN
  ,
  output logic [STALL_W-1:0]   stall_cycles
`endif
);

  localparam logic [BANK_W-1:0]  PEND_MAX   = BANK_W'(NUM_BANKS - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(NUM_ANGLES);

  state_e               state_q, state_d;
  logic [BANK_W-1:0]    pending_q, pending_d;
  logic [ANGLE_W-1:0]   angle_q, angle_d;
  logic                 scan_q, scan_d;
  logic                 pe_kick_q, pe_kick_d;
  logic                 pass_done_q, pass_done_d;
  logic [BANK_W-1:0]    fill_sel_w, shift_sel_w;
  logic                 swap_c, drain_c;

  nabp_wrap_counter #(.MODULUS(NUM_BANKS), .W(BANK_W)) u_fill_ctr (
    .clk(clk), .reset_n(reset_n), .inc(swap_c), .value(fill_sel_w)
  );

  nabp_wrap_counter #(.MODULUS(NUM_BANKS), .W(BANK_W)) u_shift_ctr (
    .clk(clk), .reset_n(reset_n), .inc(drain_c), .value(shift_sel_w)
  );

  // A full queue still accepts a bank when one drains in the same cycle.
  always_comb begin
    drain_c = (pending_q != '0) && sw_next_itr[shift_sel_w];
    swap_c  = (state_q == ST_FILL) && sw_swap_ready[fill_sel_w] &&
              ((pending_q < PEND_MAX) || drain_c);
  end

  always_comb begin
    pending_d = pending_q;
    case ({swap_c, drain_c})
      2'b10:   pending_d = pending_q + BANK_W'(1);
      2'b01:   pending_d = pending_q - BANK_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    scan_d      = scan_q ^ drain_c;
    pe_kick_d   = 1'b0;
    pass_done_d = 1'b0;
    if (swap_c) angle_d = angle_q + ANGLE_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (na_kick) begin
          state_d   = ST_PREPROCESS;
          angle_d   = '0;
          scan_d    = 1'b0;
          pe_kick_d = 1'b1;
        end
      end
      ST_PREPROCESS: if (preprocess_done) state_d = ST_FILL;
      ST_FILL:       if (swap_c && (angle_d == ANGLE_LAST)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (pending_d == '0) begin
          state_d     = ST_IDLE;
          pass_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      angle_q     <= '0;
      scan_q      <= 1'b0;
      pe_kick_q   <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      angle_q     <= angle_d;
      scan_q      <= scan_d;
      pe_kick_q   <= pe_kick_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign sw_swap         = swap_c  ? NUM_BANKS'(onehot32(32'(fill_sel_w)))  : '0;
  assign sw_next_itr_ack = drain_c ? NUM_BANKS'(onehot32(32'(shift_sel_w))) : '0;
  assign fill_sel        = fill_sel_w;
  assign shift_sel       = shift_sel_w;
  assign angle           = angle_q;
  assign pe_kick         = pe_kick_q;
  assign pe_en           = (pending_q != '0);
  assign pe_scan_mode    = scan_q;
  assign pass_done       = pass_done_q;

`ifdef SWAP_ROTATOR_STATS_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Ready bank turned away because the queue is full; saturating.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && na_kick)
      stall_d = '0;
    else if ((state_q == ST_FILL) && sw_swap_ready[fill_sel_w] && !swap_c && (stall_q != '1))
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  // Stall statistics not built.
`endif

endmodule

// File: tb/tb_nabp_swap_rotator.sv
// Directed bench for nabp_swap_rotator: a 2-bank/4-angle and a 3-bank/6-angle instance.
module tb_nabp_swap_rotator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic       k2, pp2;
  logic [1:0] rdy2, nxt2, swap2, ack2;
  logic       f2, s2;
  logic [2:0] ang2;
  logic       kick2o, en2, scan2, done2;

  logic       k3, pp3;
  logic [2:0] rdy3, nxt3, swap3, ack3;
  logic [1:0] f3, s3;
  logic [2:0] ang3;
  logic       kick3o, en3, scan3, done3;

`ifdef SWAP_ROTATOR_STATS_EN
  logic [31:0] stall2, stall3;
`endif

  nabp_swap_rotator #(.NUM_BANKS(2), .NUM_ANGLES(4)) u2 (
    .clk(clk), .reset_n(reset_n), .na_kick(k2), .preprocess_done(pp2),
    .sw_swap_ready(rdy2), .sw_next_itr(nxt2), .sw_swap(swap2), .sw_next_itr_ack(ack2),
    .fill_sel(f2), .shift_sel(s2), .angle(ang2), .pe_kick(kick2o), .pe_en(en2),
    .pe_scan_mode(scan2), .pass_done(done2)
`ifdef SWAP_ROTATOR_STATS_EN
    , .stall_cycles(stall2)
`endif
  );

  nabp_swap_rotator #(.NUM_BANKS(3), .NUM_ANGLES(6)) u3 (
    .clk(clk), .reset_n(reset_n), .na_kick(k3), .preprocess_done(pp3),
    .sw_swap_ready(rdy3), .sw_next_itr(nxt3), .sw_swap(swap3), .sw_next_itr_ack(ack3),
    .fill_sel(f3), .shift_sel(s3), .angle(ang3), .pe_kick(kick3o), .pe_en(en3),
    .pe_scan_mode(scan3), .pass_done(done3)
`ifdef SWAP_ROTATOR_STATS_EN
    , .stall_cycles(stall3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    k2 = 0; pp2 = 0; rdy2 = '0; nxt2 = '0;
    k3 = 0; pp3 = 0; rdy3 = '0; nxt3 = '0;
    #2;
    chk("rst_swap2", 32'(swap2), 0);
    chk("rst_pe_en2", 32'(en2), 0);
    chk("rst_angle3", 32'(ang3), 0);
    chk("rst_fill3", 32'(f3), 0);
    #10 reset_n = 1'b1;
    tick();

    // Test 1: 2 banks, 4 angles, everything answered at once
    k2 = 1; tick(); k2 = 0;
    chk("t1_pe_kick", 32'(kick2o), 1);
    pp2 = 1; tick(); pp2 = 0;
    chk("t1_pe_kick_low", 32'(kick2o), 0);
    rdy2 = 2'b11; nxt2 = 2'b11;
    #1 chk("t1_swap_a", 32'(swap2), 32'h1);
    chk("t1_ack_a", 32'(ack2), 0);
    tick();
    #1 chk("t1_swap_b", 32'(swap2), 32'h2);
    chk("t1_ack_b", 32'(ack2), 32'h1);
    chk("t1_pe_en", 32'(en2), 1);
    tick();
    #1 chk("t1_swap_c", 32'(swap2), 32'h1);
    chk("t1_ack_c", 32'(ack2), 32'h2);
    chk("t1_scan", 32'(scan2), 1);
    tick();
    #1 chk("t1_swap_d", 32'(swap2), 32'h2);
    chk("t1_ack_d", 32'(ack2), 32'h1);
    tick();
    #1 chk("t1_drain_noswap", 32'(swap2), 0);
    chk("t1_ack_e", 32'(ack2), 32'h2);
    chk("t1_angle", 32'(ang2), 4);
    tick();
    chk("t1_pass_done", 32'(done2), 1);
    chk("t1_pe_en_off", 32'(en2), 0);
    chk("t1_scan_even", 32'(scan2), 0);
    rdy2 = '0; nxt2 = '0;
    tick();
    chk("t1_pass_done_pulse", 32'(done2), 0);

    // Test 2: 3 banks, next_itr held low -> two swaps then blocked
    k3 = 1; tick(); k3 = 0;
    pp3 = 1; tick(); pp3 = 0;
    rdy3 = 3'b111; nxt3 = '0;
    #1 chk("t2_swap_a", 32'(swap3), 32'h1);
    tick();
    #1 chk("t2_swap_b", 32'(swap3), 32'h2);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1 chk("t2_blocked", 32'(swap3), 0);
      tick();
    end
    chk("t2_pe_en", 32'(en3), 1);
    chk("t2_angle", 32'(ang3), 2);
    chk("t2_fill", 32'(f3), 2);
    chk("t2_shift", 32'(s3), 0);
`ifdef SWAP_ROTATOR_STATS_EN
    chk("t2_stall", stall3, 10);
`endif

    // Test 3: full queue, ready and next_itr together
    nxt3 = 3'b001;
    #1 chk("t3_swap", 32'(swap3), 32'h4);
    chk("t3_ack", 32'(ack3), 32'h1);
    tick();
    nxt3 = '0;
    chk("t3_fill_wrap", 32'(f3), 0);
    chk("t3_shift", 32'(s3), 1);
    chk("t3_angle", 32'(ang3), 3);
    #1 chk("t3_still_full", 32'(swap3), 0);
    tick();
    rdy3 = '0;

    // Test 4: na_kick during FILL is ignored
    k3 = 1; tick(); k3 = 0;
    chk("t4_no_pe_kick", 32'(kick3o), 0);
    chk("t4_angle", 32'(ang3), 3);
    chk("t4_fill", 32'(f3), 0);
    chk("t4_pe_en", 32'(en3), 1);
`ifdef SWAP_ROTATOR_STATS_EN
    chk("t4_stall", stall3, 11);
`endif

    // Finish the 3-bank pass, then re-kick
    rdy3 = 3'b111; nxt3 = 3'b111;
    tick(); tick(); tick();
    chk("t4b_angle_last", 32'(ang3), 6);
    rdy3 = '0;
    tick(); tick();
    chk("t4b_pass_done", 32'(done3), 1);
    chk("t4b_pe_en_off", 32'(en3), 0);
    nxt3 = '0;
    k3 = 1; tick(); k3 = 0;
    chk("t4b_rekick", 32'(kick3o), 1);
    chk("t4b_angle_clr", 32'(ang3), 0);
`ifdef SWAP_ROTATOR_STATS_EN
    chk("t6_stall_clr", stall3, 0);
`endif

    // Test 5: async reset mid-DRAIN on the 2-bank instance
    k2 = 1; tick(); k2 = 0;
    pp2 = 1; tick(); pp2 = 0;
    rdy2 = 2'b11; nxt2 = '0;
    tick(); tick();
    nxt2 = 2'b11;
    tick(); tick(); tick();
    rdy2 = '0; nxt2 = '0;
    chk("t5_angle_pre", 32'(ang2), 4);
    chk("t5_pe_en_pre", 32'(en2), 1);
    chk("t5_scan_pre", 32'(scan2), 1);
    chk("t5_shift_pre", 32'(s2), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_pe_en_rst", 32'(en2), 0);
    chk("t5_angle_rst", 32'(ang2), 0);
    chk("t5_shift_rst", 32'(s2), 0);
    chk("t5_scan_rst", 32'(scan2), 0);
    chk("t5_fill_rst", 32'(f2), 0);
    #3 reset_n = 1'b1;
    tick();
    k2 = 1; tick(); k2 = 0;
    pp2 = 1; tick(); pp2 = 0;
    rdy2 = 2'b11;
    #1 chk("t5_restart_swap", 32'(swap2), 32'h1);
    chk("t5_restart_angle", 32'(ang2), 0);
    tick();
    chk("t5_restart_angle1", 32'(ang2), 1);
    rdy2 = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
